// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues word requests to a 1-cycle imem and queues {pc, instr} for decode.
// Latency: request to visible head is 2 cycles; redirect to first valid head is 3 cycles.
// Backpressure: stall_d holds the queue and fetch stops once queued plus in-flight words reach DEPTH.

module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (!i_push && i_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n && !i_flush && i_push) r_mem[r_wr_ptr] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rd_ptr];
    assign o_count    = r_count;
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall_d,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid_f,
    output logic [31:0] o_instr_f,
    output logic [31:0] o_pc_f,
    output logic [31:0] o_pcplus4_f
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    logic [31:0]   r_pc;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    fq_entry_t     w_head;
    fq_entry_t     w_push_dat;

    // Outputs are forced to their reset values while reset is low, even before the first reset edge.
    assign w_valid    = i_reset_n && (w_count != '0);
    assign w_pop      = w_valid && !i_stall_d && !i_redirect;
    assign w_push     = r_inflight && !i_redirect;
    assign w_occ      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    assign w_issue    = i_reset_n && !i_redirect && (w_occ < (CW+1)'(DEPTH));
    assign w_push_dat = '{pc: r_inflight_pc, instr: i_imem_rdata};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc       <= i_redirect_pc & ~32'h3;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
        end
    end

    fetch_fifo #(
        .W     ($bits(fq_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_flush    (i_redirect),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_count    (w_count)
    );

    assign o_imem_req  = w_issue;
    assign o_imem_addr = i_reset_n ? r_pc : RESET_PC;
    assign o_valid_f   = w_valid;
    assign o_instr_f   = w_valid ? w_head.instr : 32'h0000_0013;
    assign o_pc_f      = w_valid ? w_head.pc : 32'h0;
    assign o_pcplus4_f = w_valid ? w_head.pc + 32'd4 : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random stall/redirect traffic against a queue-based model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid_f;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;

    int checks = 0;
    int errors = 0;

    logic [31:0] salt = 32'h0;

    // Model state: what the fetch stage should hold, in terms of the architectural rules.
    ent_t        m_q[$];
    logic [31:0] m_pc       = RESET_PC;
    bit          m_inflight = 1'b0;
    logic [31:0] m_ipc      = RESET_PC;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_instr;
    logic [31:0] obs_pc;
    logic [31:0] obs_pc4;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_rdata  (imem_rdata),
        .i_stall_d     (stall_d),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_valid_f     (valid_f),
        .o_instr_f     (instr_f),
        .o_pc_f        (pc_f),
        .o_pcplus4_f   (pcplus4_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-latency memory: word = address ^ salt; garbage on cycles without a request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ salt;
        else          imem_rdata <= $urandom;
    end

    // The FIFO must never be written while it already holds DEPTH entries.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert (!(dut.w_push && (int'(dut.w_count) == DEPTH)))
            else begin
                errors++;
                $error("FAIL overflow: push=%0d count=%0d required no push at count=%0d",
                       dut.w_push, dut.w_count, DEPTH);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc);
        bit          e_valid;
        bit          e_pop;
        bit          e_req;
        ent_t        e_head;
        reset_n     = rst;
        stall_d     = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        e_valid = rst && (m_q.size() > 0);
        e_head  = e_valid ? m_q[0] : '0;
        e_pop   = e_valid && !st && !rd;
        e_req   = rst && !rd && ((m_q.size() + int'(m_inflight) - int'(e_pop)) < DEPTH);
        chk("imem_req",  {31'b0, imem_req}, {31'b0, e_req});
        chk("imem_addr", imem_addr, rst ? m_pc : RESET_PC);
        chk("valid_f",   {31'b0, valid_f}, {31'b0, e_valid});
        chk("instr_f",   instr_f, e_valid ? e_head.instr : 32'h0000_0013);
        chk("pc_f",      pc_f, e_valid ? e_head.pc : 32'h0);
        chk("pcplus4_f", pcplus4_f, e_valid ? e_head.pc + 32'd4 : 32'h0);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = valid_f;
        obs_instr = instr_f;
        obs_pc    = pc_f;
        obs_pc4   = pcplus4_f;
        if (!rst) begin
            m_q.delete();
            m_pc       = RESET_PC;
            m_inflight = 1'b0;
        end else if (rd) begin
            m_q.delete();
            m_pc       = {rpc[31:2], 2'b00};
            m_inflight = 1'b0;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back('{pc: m_ipc, instr: m_ipc ^ salt});
            if (e_req) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd4;
            end
            m_inflight = e_req;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        stall_d     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0);
        chk("rst_valid", {31'b0, obs_valid}, 32'h0);
        chk("rst_addr", obs_addr, RESET_PC);

        // Reset release and steady stream, memory word equal to address.
        step(1, 0, 0, 32'h0);
        chk("c0_req", {31'b0, obs_req}, 32'h1);
        chk("c0_addr", obs_addr, 32'h100);
        step(1, 0, 0, 32'h0);
        chk("c1_valid", {31'b0, obs_valid}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("c2_valid", {31'b0, obs_valid}, 32'h1);
        chk("c2_pc", obs_pc, 32'h100);
        chk("c2_instr", obs_instr, 32'h100);
        chk("c2_pc4", obs_pc4, 32'h104);
        step(1, 0, 0, 32'h0);
        chk("c3_pc", obs_pc, 32'h104);
        step(1, 0, 0, 32'h0);

        // Stall cycles 5..9: head frozen at 0x10C, fetch stops once the queue fills.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'h0);
        chk("stall_req_low", {31'b0, obs_req}, 32'h0);
        chk("stall_head", obs_pc, 32'h10C);
        step(1, 0, 0, 32'h0);
        chk("unstall_head", obs_pc, 32'h10C);
        step(1, 0, 0, 32'h0);
        chk("unstall_next", obs_pc, 32'h110);
        step(1, 0, 0, 32'h0);
        chk("unstall_nobubble", obs_pc, 32'h114);
        step(1, 0, 0, 32'h0);

        // Redirect to a misaligned target; in-flight response dropped.
        salt = 32'h0F0F_0000;
        step(1, 0, 1, 32'h0000_2003);
        chk("redir_noreq", {31'b0, obs_req}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("redir_r1_addr", obs_addr, 32'h2000);
        chk("redir_r1_valid", {31'b0, obs_valid}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("redir_r2_valid", {31'b0, obs_valid}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("redir_r3_pc", obs_pc, 32'h2000);
        chk("redir_r3_instr", obs_instr, 32'h2000 ^ 32'h0F0F_0000);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h0);

        // Redirect wins over stall with a full queue.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0);
        chk("full_req_low", {31'b0, obs_req}, 32'h0);
        salt = 32'h00FF_0000;
        step(1, 1, 1, 32'h0000_3000);
        step(1, 0, 0, 32'h0);
        chk("rs_r1_addr", obs_addr, 32'h3000);
        chk("rs_r1_valid", {31'b0, obs_valid}, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("rs_r3_pc", obs_pc, 32'h3000);

        // Address wrap at the top of the space.
        salt = 32'h1234_0000;
        step(1, 0, 1, 32'hFFFF_FFF8);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("wrap_pc0", obs_pc, 32'hFFFF_FFF8);
        step(1, 0, 0, 32'h0);
        chk("wrap_pc1", obs_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", obs_pc4, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("wrap_pc2", obs_pc, 32'h0);

        // Random stall/redirect traffic.
        for (int i = 0; i < 400; i++) begin
            bit rd;
            rd = ($urandom_range(0, 19) == 0);
            if (rd) salt = $urandom;
            step(1, $urandom_range(0, 2) == 0, rd, $urandom);
        end

        // One-cycle reset pulse with a full queue.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        chk("pulse_valid", {31'b0, obs_valid}, 32'h0);
        chk("pulse_req", {31'b0, obs_req}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("pulse_c0_addr", obs_addr, RESET_PC);
        step(1, 0, 0, 32'h0);
        chk("pulse_c1_valid", {31'b0, obs_valid}, 32'h0);
        step(1, 0, 0, 32'h0);
        chk("pulse_c2_pc", obs_pc, RESET_PC);

        for (int i = 0; i < 100; i++) begin
            bit rd;
            rd = ($urandom_range(0, 19) == 0);
            if (rd) salt = $urandom;
            step(1, $urandom_range(0, 2) == 0, rd, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
